// File: rtl/pwm_pkg.sv
// Shared constants and the duty compare used by the PWM peripheral.
package pwm_pkg;

   localparam int                   PWM_CNT_W     = 8;
   localparam logic [PWM_CNT_W-1:0] PWM_DUTY_FULL = 8'hFF;
   localparam int                   NUM_OUTPUTS   = 16;

   // Full-scale duty forces a solid high level; otherwise high while the
   // period counter is below the duty value, so 0x00 stays low.
   function automatic logic pwm_level(input logic [PWM_CNT_W-1:0] count,
                                      input logic [PWM_CNT_W-1:0] duty);
      return (duty == PWM_DUTY_FULL) || (count < duty);
   endfunction

endpackage

// File: rtl/pwm_timebase.sv
// Prescaler plus 8-bit period counter; flags the period wrap and pulses
// period_start on the clk that follows it.
module pwm_timebase
   import pwm_pkg::*;
#(
   parameter int CLK_DIV = 3000
) (
   input  logic                 clk,
   input  logic                 rst_n,
   output logic                 wrap,
   output logic [PWM_CNT_W-1:0] count,
   output logic                 period_start
);

   localparam logic [15:0] PRE_LAST = 16'(CLK_DIV - 1);

   logic [15:0] prescale;
   logic        tick;

   assign tick = (prescale == PRE_LAST);
   assign wrap = tick && (count == {PWM_CNT_W{1'b1}});

   // Prescaler: counts 0..CLK_DIV-1 and restarts at 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    prescale <= '0;
      else if (tick) prescale <= '0;
      else           prescale <= prescale + 16'd1;
   end

   // Period counter: one step per tick, natural 255 -> 0 rollover.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    count <= '0;
      else if (tick) count <= count + PWM_CNT_W'(1);
   end

   // Period start: high for the single clk in which the counter reads 0
   // after a wrap.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) period_start <= 1'b0;
      else        period_start <= wrap;
   end

endmodule

// File: rtl/pwm_peripheral.sv
// 16-output PWM peripheral: per-bit enable and PWM/static-on mode, one
// shared PWM waveform whose duty is latched only at period boundaries.
module pwm_peripheral
   import pwm_pkg::*;
#(
   parameter int CLK_DIV = 3000
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [7:0]             en_reg_out_7_0,
   input  logic [7:0]             en_reg_out_15_8,
   input  logic [7:0]             en_reg_pwm_7_0,
   input  logic [7:0]             en_reg_pwm_15_8,
   input  logic [7:0]             pwm_duty_cycle,
   output logic [NUM_OUTPUTS-1:0] out,
   output logic                   period_start
);

   logic [NUM_OUTPUTS-1:0] en_out;
   logic [NUM_OUTPUTS-1:0] en_pwm;
   logic                   wrap;
   logic [PWM_CNT_W-1:0]   count;
   logic [PWM_CNT_W-1:0]   duty_shadow;
   logic                   pwm_signal;

   assign en_out = {en_reg_out_15_8, en_reg_out_7_0};
   assign en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};

   pwm_timebase #(
      .CLK_DIV (CLK_DIV)
   ) u_timebase (
      .clk          (clk),
      .rst_n        (rst_n),
      .wrap         (wrap),
      .count        (count),
      .period_start (period_start)
   );

   // Duty shadow: only reloaded on the wrap tick so a period never sees
   // its compare value change part way through.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    duty_shadow <= '0;
      else if (wrap) duty_shadow <= pwm_duty_cycle;
   end

   assign pwm_signal = pwm_level(count, duty_shadow);

   // Output mux: disabled -> 0, static mode -> 1, PWM mode -> shared
   // waveform; enables act on the next clk, not at a period boundary.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) out <= '0;
      else        out <= en_out & (~en_pwm | {NUM_OUTPUTS{pwm_signal}});
   end

endmodule

// File: tb/tb_pwm_peripheral.sv
// Scoreboard bench for pwm_peripheral: CLK_DIV=4 main instance plus
// CLK_DIV=2 and CLK_DIV=5 instances for period_start spacing.
module tb_pwm_peripheral;

   localparam int P4 = 1024;
   localparam int P2 = 512;
   localparam int P5 = 1280;

   typedef struct packed {
      logic [15:0] out;
      logic        ps;
      logic        ps2;
      logic        ps5;
   } exp_t;

   logic        clk    = 1'b0;
   logic        rst_n  = 1'b0;
   logic [15:0] en_out = '0;
   logic [15:0] en_pwm = '0;
   logic [7:0]  duty   = '0;
   logic [15:0] out, out2, out5;
   logic        ps, ps2, ps5;

   exp_t        sb_q[$];
   exp_t        e;
   int          m_n    = 0;
   logic [7:0]  m_sh   = '0;
   int          n_cmp  = 0;
   int          n_bad  = 0;

   always #5 clk = ~clk;

   pwm_peripheral #(.CLK_DIV(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .en_reg_out_7_0(en_out[7:0]), .en_reg_out_15_8(en_out[15:8]),
      .en_reg_pwm_7_0(en_pwm[7:0]), .en_reg_pwm_15_8(en_pwm[15:8]),
      .pwm_duty_cycle(duty), .out(out), .period_start(ps));

   pwm_peripheral #(.CLK_DIV(2)) dut2 (
      .clk(clk), .rst_n(rst_n),
      .en_reg_out_7_0(en_out[7:0]), .en_reg_out_15_8(en_out[15:8]),
      .en_reg_pwm_7_0(en_pwm[7:0]), .en_reg_pwm_15_8(en_pwm[15:8]),
      .pwm_duty_cycle(duty), .out(out2), .period_start(ps2));

   pwm_peripheral #(.CLK_DIV(5)) dut5 (
      .clk(clk), .rst_n(rst_n),
      .en_reg_out_7_0(en_out[7:0]), .en_reg_out_15_8(en_out[15:8]),
      .en_reg_pwm_7_0(en_pwm[7:0]), .en_reg_pwm_15_8(en_pwm[15:8]),
      .pwm_duty_cycle(duty), .out(out5), .period_start(ps5));

   // Predict the outputs after the next edge from the clk count since reset
   // release, push them, then advance one clk.
   task automatic step();
      exp_t x;
      int   cnt;
      logic pwm;
      cnt   = (m_n / 4) % 256;
      pwm   = (m_sh == 8'hFF) || (cnt < int'(m_sh));
      x.out = en_out & (~en_pwm | {16{pwm}});
      x.ps  = ((m_n + 1) % P4) == 0;
      x.ps2 = ((m_n + 1) % P2) == 0;
      x.ps5 = ((m_n + 1) % P5) == 0;
      sb_q.push_back(x);
      @(posedge clk);
      if (x.ps) m_sh = duty;
      m_n++;
      #1;
   endtask

   task automatic test_reset();
      en_out = 16'hFFFF; en_pwm = 16'h0000; duty = 8'h80;
      repeat (3) @(posedge clk);
      #1;
      n_cmp++; if (out !== 16'h0000) begin n_bad++; $display("FAIL reset_out got %h want 0000", out); end
      n_cmp++; if (ps !== 1'b0) begin n_bad++; $display("FAIL reset_ps got %b want 0", ps); end
      n_cmp++; if (out2 !== 16'h0000 || out5 !== 16'h0000) begin n_bad++; $display("FAIL reset_out25 got %h/%h want 0000", out2, out5); end
      n_cmp++; if (ps2 !== 1'b0 || ps5 !== 1'b0) begin n_bad++; $display("FAIL reset_ps25 got %b/%b want 0", ps2, ps5); end
      @(negedge clk);
      rst_n = 1'b1; m_n = 0; m_sh = '0; sb_q.delete();
      step();
      e = sb_q.pop_front();
      n_cmp++; if (out !== 16'hFFFF) begin n_bad++; $display("FAIL static_on_release got %h want ffff", out); end
      n_cmp++; if (out !== e.out) begin n_bad++; $display("FAIL release_out got %h want %h", out, e.out); end
      en_out = 16'h0001; en_pwm = 16'h0001;
   endtask

   task automatic test_duty_half();
      int hi1 = 0, hi2 = 0, pulses = 0;
      while (m_n < 3 * P4) begin
         step();
         e = sb_q.pop_front();
         n_cmp++; if (out !== e.out) begin n_bad++; $display("FAIL half_out n=%0d got %h want %h", m_n, out, e.out); end
         n_cmp++; if (ps !== e.ps) begin n_bad++; $display("FAIL half_ps n=%0d got %b want %b", m_n, ps, e.ps); end
         if ((m_n - 1) / P4 == 1) hi1 += int'(out[0]);
         if ((m_n - 1) / P4 == 2) hi2 += int'(out[0]);
         if (ps === 1'b1) pulses++;
      end
      n_cmp++; if (hi1 != 512) begin n_bad++; $display("FAIL half_hi_p1 got %0d want 512", hi1); end
      n_cmp++; if (hi2 != 512) begin n_bad++; $display("FAIL half_hi_p2 got %0d want 512", hi2); end
      n_cmp++; if (pulses != 3) begin n_bad++; $display("FAIL half_pulses got %0d want 3", pulses); end
   endtask

   task automatic test_duty_extremes();
      int hi4 = 0, hi6 = 0;
      duty = 8'h00;
      while (m_n < 5 * P4) begin
         step();
         e = sb_q.pop_front();
         n_cmp++; if (out !== e.out) begin n_bad++; $display("FAIL zero_out n=%0d got %h want %h", m_n, out, e.out); end
         if ((m_n - 1) / P4 == 4) hi4 += int'(out[0]);
      end
      duty = 8'hFF;
      while (m_n < 7 * P4) begin
         step();
         e = sb_q.pop_front();
         n_cmp++; if (out !== e.out) begin n_bad++; $display("FAIL full_out n=%0d got %h want %h", m_n, out, e.out); end
         if ((m_n - 1) / P4 == 6) hi6 += int'(out[0]);
      end
      n_cmp++; if (hi4 != 0) begin n_bad++; $display("FAIL zero_hi got %0d want 0", hi4); end
      n_cmp++; if (hi6 != 1024) begin n_bad++; $display("FAIL full_hi got %0d want 1024", hi6); end
   endtask

   task automatic test_mid_change();
      int hi8 = 0, hi9 = 0;
      duty = 8'h40;
      while (m_n < 10 * P4) begin
         if (m_n == 8 * P4 + 400) duty = 8'hC0;
         step();
         e = sb_q.pop_front();
         n_cmp++; if (out !== e.out) begin n_bad++; $display("FAIL mid_out n=%0d got %h want %h", m_n, out, e.out); end
         if ((m_n - 1) / P4 == 8) hi8 += int'(out[0]);
         if ((m_n - 1) / P4 == 9) hi9 += int'(out[0]);
      end
      n_cmp++; if (hi8 != 256) begin n_bad++; $display("FAIL mid_hi_old got %0d want 256", hi8); end
      n_cmp++; if (hi9 != 768) begin n_bad++; $display("FAIL mid_hi_new got %0d want 768", hi9); end
   endtask

   task automatic test_mixed();
      int hi11 = 0, unlocked = 0;
      en_out = 16'hFFFF; en_pwm = 16'h00FF; duty = 8'h80;
      while (m_n < 12 * P4) begin
         step();
         e = sb_q.pop_front();
         n_cmp++; if (out !== e.out) begin n_bad++; $display("FAIL mixed_out n=%0d got %h want %h", m_n, out, e.out); end
         if (out[15:8] !== 8'hFF || (out[7:0] !== 8'h00 && out[7:0] !== 8'hFF)) unlocked++;
         if ((m_n - 1) / P4 == 11) hi11 += int'(out[0]);
      end
      n_cmp++; if (unlocked != 0) begin n_bad++; $display("FAIL mixed_lockstep got %0d bad clk want 0", unlocked); end
      n_cmp++; if (hi11 != 512) begin n_bad++; $display("FAIL mixed_hi got %0d want 512", hi11); end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 300; i++) begin
         en_out = 16'($urandom);
         en_pwm = 16'($urandom);
         duty   = 8'($urandom);
         step();
         e = sb_q.pop_front();
         n_cmp++; if (out !== e.out) begin n_bad++; $display("FAIL b2b_out n=%0d got %h want %h", m_n, out, e.out); end
         n_cmp++; if (ps !== e.ps) begin n_bad++; $display("FAIL b2b_ps n=%0d got %b want %b", m_n, ps, e.ps); end
      end
   endtask

   task automatic test_reset_mid();
      int target;
      int first_ps = -1;
      en_out = 16'h0001; en_pwm = 16'h0001; duty = 8'h80;
      target = ((m_n / P4) + 2) * P4 + 200;
      while (m_n < target) begin
         step();
         e = sb_q.pop_front();
         n_cmp++; if (out !== e.out) begin n_bad++; $display("FAIL pre_rst_out n=%0d got %h want %h", m_n, out, e.out); end
      end
      rst_n = 1'b0;
      #1;
      n_cmp++; if (out !== 16'h0000) begin n_bad++; $display("FAIL midrst_out got %h want 0000", out); end
      n_cmp++; if (ps !== 1'b0) begin n_bad++; $display("FAIL midrst_ps got %b want 0", ps); end
      repeat (2) @(posedge clk);
      #1;
      n_cmp++; if (out !== 16'h0000) begin n_bad++; $display("FAIL midrst_hold got %h want 0000", out); end
      @(negedge clk);
      rst_n = 1'b1; m_n = 0; m_sh = '0; sb_q.delete();
      while (m_n < 1100) begin
         step();
         e = sb_q.pop_front();
         n_cmp++; if (out !== e.out) begin n_bad++; $display("FAIL post_rst_out n=%0d got %h want %h", m_n, out, e.out); end
         n_cmp++; if (ps !== e.ps) begin n_bad++; $display("FAIL post_rst_ps n=%0d got %b want %b", m_n, ps, e.ps); end
         if (ps === 1'b1 && first_ps < 0) first_ps = m_n;
      end
      n_cmp++; if (first_ps != 1024) begin n_bad++; $display("FAIL first_ps got %0d want 1024", first_ps); end
   endtask

   task automatic test_period_start_div();
      int last2 = -1, last5 = -1, cnt2 = 0, cnt5 = 0;
      while (m_n < 3900) begin
         step();
         e = sb_q.pop_front();
         n_cmp++; if (ps2 !== e.ps2) begin n_bad++; $display("FAIL div2_ps n=%0d got %b want %b", m_n, ps2, e.ps2); end
         n_cmp++; if (ps5 !== e.ps5) begin n_bad++; $display("FAIL div5_ps n=%0d got %b want %b", m_n, ps5, e.ps5); end
         if (ps2 === 1'b1) begin
            if (last2 >= 0) begin
               n_cmp++; if (m_n - last2 != P2) begin n_bad++; $display("FAIL div2_gap got %0d want %0d", m_n - last2, P2); end
            end
            last2 = m_n; cnt2++;
         end
         if (ps5 === 1'b1) begin
            if (last5 >= 0) begin
               n_cmp++; if (m_n - last5 != P5) begin n_bad++; $display("FAIL div5_gap got %0d want %0d", m_n - last5, P5); end
            end
            last5 = m_n; cnt5++;
         end
      end
      n_cmp++; if (cnt2 != 5) begin n_bad++; $display("FAIL div2_count got %0d want 5", cnt2); end
      n_cmp++; if (cnt5 != 3) begin n_bad++; $display("FAIL div5_count got %0d want 3", cnt5); end
   endtask

   initial begin
      test_reset();
      test_duty_half();
      test_duty_extremes();
      test_mid_change();
      test_mixed();
      test_back_to_back();
      test_reset_mid();
      test_period_start_div();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout at n=%0d", m_n);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/pwm_peripheral.md
PWM_PERIPHERAL -- requirements
Module: pwm_peripheral

Interface
REQ-001 SHALL have parameter CLK_DIV, default 3000: clk cycles per PWM counter step; legal range 2..65535.
REQ-002 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port en_reg_out_7_0  input  8  output enable, bits 7:0.
REQ-005 SHALL have port en_reg_out_15_8  input  8  output enable, bits 15:8.
REQ-006 SHALL have port en_reg_pwm_7_0  input  8  PWM mode select, bits 7:0.
REQ-007 SHALL have port en_reg_pwm_15_8  input  8  PWM mode select, bits 15:8.
REQ-008 SHALL have port pwm_duty_cycle  input  8  requested duty, 0x00 = 0%, 0xFF = 100%.
REQ-009 SHALL have port out  output  16  driven outputs.
REQ-010 SHALL have port period_start  output  1  one-clk pulse at each PWM period start.

Function
REQ-011 SHALL treat all inputs as synchronous to clk and register-stable, with no synchronizers.
REQ-012 SHALL run a prescaler counting 0..CLK_DIV-1, wrapping to 0.
- Tick asserted for one clk when prescaler == CLK_DIV-1.
REQ-013 SHALL advance an 8-bit period counter by 1 on each tick, wrapping 255 -> 0.
- Period = 256*CLK_DIV clk.
REQ-014 SHALL hold a duty shadow register, loaded from pwm_duty_cycle only on the tick that wraps the period counter 255 -> 0.
- Mid-period duty changes take effect at the next period start; no glitch and no runt pulse.
REQ-015 SHALL pulse period_start high for the single clk following that wrap tick, coincident with the period counter reading 0.
REQ-016 SHALL compute pwm_signal = 1 when shadow == 0xFF, else (period_counter < shadow).
- 0x00 gives constant low.
- N gives N*CLK_DIV high clk per period.
REQ-017 SHALL, for each bit i, register out[i] as follows:
- en_out[i] == 0: out[i] = 0.
- en_out[i] == 1 and en_pwm[i] == 0: out[i] = 1.
- en_out[i] == 1 and en_pwm[i] == 1: out[i] = pwm_signal.
REQ-018 SHALL apply enable/mode changes on out one clk after the input change, without waiting for a period boundary.
REQ-019 SHALL drive all PWM-mode bits from one shared pwm_signal, so they switch on the same clk edge.
REQ-020 SHALL, when a tick and a duty input change fall on the same clk, load the shadow with the value sampled on that clk edge.

Reset
REQ-021 SHALL, while rst_n is low, asynchronously clear prescaler, period counter, duty shadow, out (0x0000) and period_start (0).
REQ-022 SHALL, on rst_n release, start the first period with prescaler=0, counter=0 and shadow=0.
- Output stays low in PWM mode until the first wrap loads the duty.
- Static-on bits go high one clk after release.
REQ-023 SHALL, on reset mid-period, discard the partial period and in-flight duty without recovery.

Structure
REQ-024 SHALL place constants PWM_CNT_W=8, PWM_DUTY_FULL=8'hFF and NUM_OUTPUTS=16 in shared package pwm_pkg.
REQ-025 SHALL implement the prescaler, period counter, tick and period_start in sub-module pwm_timebase (parameter CLK_DIV).
- Duty shadow, compare and output muxing remain in pwm_peripheral.

Verification
REQ-026 SHALL, with CLK_DIV=4, duty=0x80, en_out=0x0001, en_pwm=0x0001, observe on out[0]: 512 clk high then 512 clk low, repeating every 1024 clk.
REQ-027 SHALL, with duty=0x00, see out[0] held low; with duty=0xFF, see out[0] held high across the full 1024-clk period.
REQ-028 SHALL, changing duty 0x40 -> 0xC0 at counter=100, see the current period finish with 256 high clk and the next period run 768 high clk.
REQ-029 SHALL, with en_out=0xFFFF, en_pwm=0x00FF, duty=0x80, see out[15:8]=0xFF constant and out[7:0] toggling 0x00/0xFF in lockstep.
REQ-030 SHALL, asserting rst_n low at counter=50, see out=0x0000 and period_start=0 immediately.
- After release, first period_start after 1024 clk.
REQ-031 SHALL check period_start is exactly one clk wide and occurs every 256*CLK_DIV clk for CLK_DIV values 2 and 5.
